servo_pan_tilt: RTL and testbench
=================================

SERVO_PAN_TILT -- requirements
Module: servo_pan_tilt

Interface
REQ-001 SHALL expose parameter PERIOD_CYC, default 500000, meaning clocks per servo frame (20 ms at 25 MHz).
REQ-002 SHALL expose parameter MIN_CYC, default 25000, meaning pulse width at position 0 (1 ms).
REQ-003 SHALL expose parameter STEP_CYC, default 98, meaning added pulse cycles per position unit.
REQ-004 SHALL expose parameter POS_MAX, default 255, meaning upper position limit.
REQ-005 SHALL expose parameter CENTER, default 128, meaning reset position.
REQ-006 SHALL expose parameter FIRE_CYC, default 2500000, meaning fire pulse length (100 ms).
REQ-007 SHALL expose parameter COOL_CYC, default 12500000, meaning lockout after fire (500 ms).
REQ-008 SHALL have port i_clk  in  1  the single system clock.
REQ-009 SHALL have port i_rst  in  1  the reset, synchronous and active-high.
REQ-010 SHALL have ports i_right, i_left, i_up, i_down, each in  1  a direction level from the command decoder, synchronous to i_clk.
REQ-011 SHALL have port i_trigger  in  1  the fire request level from the command decoder.
REQ-012 SHALL have ports o_pan_pwm and o_tilt_pwm, each out  1  a servo pulse train.
REQ-013 SHALL have ports o_pan_pos and o_tilt_pos, each out  8  the current position.
REQ-014 SHALL have port o_fire  out  1  the fire actuator drive.
REQ-015 SHALL have port o_busy  out  1  high while the fire FSM is in FIRE or COOLDOWN.

Function
REQ-016 SHALL run a frame counter 0..PERIOD_CYC-1 that wraps to 0; frame 0 starts on the first clock after reset deasserts.
REQ-017 SHALL update positions only on the last cycle of a frame (count = PERIOD_CYC-1), using input levels sampled that cycle, so each new position applies from the next frame.
REQ-018 SHALL handle pan as follows: i_right alone adds +1; i_left alone adds -1; both or neither leave pan unchanged.
REQ-019 SHALL handle tilt as follows: i_up alone adds +1; i_down alone adds -1; both or neither leave tilt unchanged.
REQ-020 SHALL saturate positions at 0 and POS_MAX, with no wrap-around.
REQ-021 SHALL drive each PWM output high for exactly MIN_CYC + pos*STEP_CYC consecutive cycles at the start of every frame and low for the rest; all outputs are registered and glitch-free.
REQ-022 SHALL compute pulse width with at least 20-bit unsigned arithmetic; a width of at least PERIOD_CYC is clamped to PERIOD_CYC-1.
REQ-023 SHALL implement the fire FSM with states IDLE, FIRE and COOLDOWN.
REQ-024 SHALL make the transition IDLE->FIRE on a rising edge of i_trigger (previous sample 0, current 1).
REQ-025 SHALL make the transition FIRE->COOLDOWN after exactly FIRE_CYC cycles, and COOLDOWN->IDLE after exactly COOL_CYC cycles.
REQ-026 SHALL assert o_fire only in FIRE, starting the cycle after the edge is detected.
REQ-027 SHALL discard rising edges outside IDLE; a trigger held high through COOLDOWN does not refire, and a new 0->1 edge is required.
REQ-028 SHALL operate the fire FSM and position logic independently; simultaneous trigger and direction inputs are both serviced.

Reset
REQ-029 SHALL, on i_rst high at a clock edge, set the following: frame counter 0, o_pan_pos=o_tilt_pos=CENTER, FSM IDLE, o_fire=0, o_busy=0, o_pan_pwm=o_tilt_pwm=0, and the trigger edge register=1 (a held trigger does not fire after reset).
REQ-030 SHALL, on reset asserted mid-pulse or mid-FIRE, force all outputs to reset values at the next edge, abandoning the in-progress frame or fire without completing it.

Verification (PERIOD_CYC=100, MIN_CYC=10, STEP_CYC=1, POS_MAX=20, CENTER=10, FIRE_CYC=5, COOL_CYC=8)
REQ-031 SHALL verify: reset release, no inputs -> each PWM output is high 20 cycles and low 80 cycles per frame; positions=10; o_fire=0.
REQ-032 SHALL verify: i_right held for 15 frames -> o_pan_pos steps 11..20, then holds at 20; pan pulse width 30; tilt unchanged at 10.
REQ-033 SHALL verify: i_left and i_right high together for 3 frames, plus i_down for 3 frames -> pan=10, tilt=7, tilt width 17.
REQ-034 SHALL verify: i_trigger 0->1 held for 30 cycles -> o_fire high for 5 cycles, o_busy high for 13 cycles, then exactly one fire.
REQ-035 SHALL verify: second trigger edge during COOLDOWN -> ignored; a trigger edge after returning to IDLE -> fires again.
REQ-036 SHALL verify: i_rst pulsed during FIRE and mid-pulse, with pan=15 -> next cycle o_fire=0, pan=10, and PWM restarts from frame 0.

Source files
------------

// File: rtl/servo_pan_tilt.sv
// Pan/tilt servo driver: two frame-locked PWM channels whose positions step once per
// frame from direction levels, plus an edge-triggered fire pulse with a cooldown lockout.
module servo_pan_tilt #(
   parameter int PERIOD_CYC = 500000,
   parameter int MIN_CYC    = 25000,
   parameter int STEP_CYC   = 98,
   parameter int POS_MAX    = 255,
   parameter int CENTER     = 128,
   parameter int FIRE_CYC   = 2500000,
   parameter int COOL_CYC   = 12500000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_right,
   input  logic       i_left,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_trigger,
   output logic       o_pan_pwm,
   output logic       o_tilt_pwm,
   output logic [7:0] o_pan_pos,
   output logic [7:0] o_tilt_pos,
   output logic       o_fire,
   output logic       o_busy
);

   localparam int CW   = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
   localparam int TMAX = (FIRE_CYC > COOL_CYC) ? FIRE_CYC : COOL_CYC;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

   localparam logic [CW-1:0] LAST_CNT  = CW'(PERIOD_CYC - 1);
   localparam logic [TW-1:0] FIRE_LAST = TW'(FIRE_CYC - 1);
   localparam logic [TW-1:0] COOL_LAST = TW'(COOL_CYC - 1);
   localparam logic [7:0]    POS_TOP   = 8'(POS_MAX);
   localparam logic [7:0]    POS_RST   = 8'(CENTER);
   localparam logic [31:0]   PERIOD_W  = 32'(PERIOD_CYC);
   localparam logic [31:0]   MIN_W     = 32'(MIN_CYC);
   localparam logic [31:0]   STEP_W    = 32'(STEP_CYC);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_COOL = 2'd2
   } state_t;

   // One saturating position step; opposing or absent requests hold the position.
   function automatic logic [7:0] pos_step(input logic [7:0] pos, input logic inc,
                                           input logic dec);
      logic [7:0] res;
      res = pos;
      if (inc && !dec && (pos < POS_TOP)) begin
         res = pos + 8'd1;
      end else if (dec && !inc && (pos > 8'd0)) begin
         res = pos - 8'd1;
      end else begin
         res = pos;
      end
      return res;
   endfunction

   function automatic logic [CW-1:0] pulse_width(input logic [7:0] pos);
      logic [31:0] w;
      w = MIN_W + (32'(pos) * STEP_W);
      if (w >= PERIOD_W) begin
         w = PERIOD_W - 32'd1;
      end else begin
         w = w;
      end
      return CW'(w);
   endfunction

   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    pan_q, pan_d, tilt_q, tilt_d;
   logic          pan_pwm_q, pan_pwm_d, tilt_pwm_q, tilt_pwm_d;
   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          trig_q;
   logic          fire_q, fire_d, busy_q, busy_d;
   logic          frame_end_s, trig_edge_s;

   assign frame_end_s = (cnt_q == LAST_CNT);
   assign trig_edge_s = i_trigger & ~trig_q;

   // Frame counter, once-per-frame position update and PWM compare.
   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      pan_d  = pan_q;
      tilt_d = tilt_q;
      if (frame_end_s) begin
         cnt_d  = {CW{1'b0}};
         pan_d  = pos_step(pan_q, i_right, i_left);
         tilt_d = pos_step(tilt_q, i_up, i_down);
      end else begin
         cnt_d  = cnt_q + CW'(1);
      end
      pan_pwm_d  = (cnt_q < pulse_width(pan_q));
      tilt_pwm_d = (cnt_q < pulse_width(tilt_q));
   end

   // Fire sequencer: a trigger edge is honoured only from IDLE.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (trig_edge_s) begin
               state_d = ST_FIRE;
               timer_d = {TW{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FIRE: begin
            if (timer_q == FIRE_LAST) begin
               state_d = ST_COOL;
               timer_d = {TW{1'b0}};
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_COOL: begin
            if (timer_q == COOL_LAST) begin
               state_d = ST_IDLE;
               timer_d = {TW{1'b0}};
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = {TW{1'b0}};
         end
      endcase
      fire_d = (state_d == ST_FIRE);
      busy_d = (state_d != ST_IDLE);
   end

   // State registers; the trigger history resets high so a held trigger cannot fire.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q      <= {CW{1'b0}};
         pan_q      <= POS_RST;
         tilt_q     <= POS_RST;
         pan_pwm_q  <= 1'b0;
         tilt_pwm_q <= 1'b0;
         state_q    <= ST_IDLE;
         timer_q    <= {TW{1'b0}};
         trig_q     <= 1'b1;
         fire_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         pan_q      <= pan_d;
         tilt_q     <= tilt_d;
         pan_pwm_q  <= pan_pwm_d;
         tilt_pwm_q <= tilt_pwm_d;
         state_q    <= state_d;
         timer_q    <= timer_d;
         trig_q     <= i_trigger;
         fire_q     <= fire_d;
         busy_q     <= busy_d;
      end
   end

   assign o_pan_pwm  = pan_pwm_q;
   assign o_tilt_pwm = tilt_pwm_q;
   assign o_pan_pos  = pan_q;
   assign o_tilt_pos = tilt_q;
   assign o_fire     = fire_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_servo_pan_tilt.sv
// Self-checking bench for servo_pan_tilt: directed scenarios plus random traffic,
// compared every cycle against a frame/countdown reference model.
module tb_servo_pan_tilt;

   localparam int P     = 100;
   localparam int MINC  = 10;
   localparam int STEP  = 1;
   localparam int PMAX  = 20;
   localparam int CTR   = 10;
   localparam int FIRE  = 5;
   localparam int COOL  = 8;

   logic       clk;
   logic       i_rst, i_right, i_left, i_up, i_down, i_trigger;
   logic       o_pan_pwm, o_tilt_pwm, o_fire, o_busy;
   logic [7:0] o_pan_pos, o_tilt_pos;

   servo_pan_tilt #(
      .PERIOD_CYC(P), .MIN_CYC(MINC), .STEP_CYC(STEP), .POS_MAX(PMAX),
      .CENTER(CTR), .FIRE_CYC(FIRE), .COOL_CYC(COOL)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_right(i_right), .i_left(i_left),
      .i_up(i_up), .i_down(i_down), .i_trigger(i_trigger),
      .o_pan_pwm(o_pan_pwm), .o_tilt_pwm(o_tilt_pwm),
      .o_pan_pos(o_pan_pos), .o_tilt_pos(o_tilt_pos),
      .o_fire(o_fire), .o_busy(o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: n_m = clocks since reset release, fire/cool as remaining-cycle counts.
   int n_m, pan_m, tilt_m, fire_left, cool_left;
   bit prev_m;
   bit exp_ppwm, exp_tpwm, exp_fire, exp_busy;

   int pan_hi, tilt_hi, fire_hi, busy_hi, fire_rises;
   bit last_fire;

   function automatic int width_of(input int pos);
      int w;
      w = MINC + pos * STEP;
      return (w >= P) ? P - 1 : w;
   endfunction

   function automatic int sat(input int v);
      return (v < 0) ? 0 : ((v > PMAX) ? PMAX : v);
   endfunction

   task automatic model_edge(input bit r, l, u, d, t, rs);
      if (rs) begin
         n_m = 0; pan_m = CTR; tilt_m = CTR;
         fire_left = 0; cool_left = 0; prev_m = 1'b1;
         exp_ppwm = 1'b0; exp_tpwm = 1'b0;
      end else begin
         exp_ppwm = ((n_m % P) < width_of(pan_m));
         exp_tpwm = ((n_m % P) < width_of(tilt_m));
         if ((n_m % P) == P - 1) begin
            pan_m  = sat(pan_m + ((r && !l) ? 1 : ((l && !r) ? -1 : 0)));
            tilt_m = sat(tilt_m + ((u && !d) ? 1 : ((d && !u) ? -1 : 0)));
         end
         n_m++;
         if (fire_left > 0) begin
            fire_left--;
            if (fire_left == 0) cool_left = COOL;
         end else if (cool_left > 0) begin
            cool_left--;
         end else if (t && !prev_m) begin
            fire_left = FIRE;
         end
         prev_m = t;
      end
      exp_fire = (fire_left > 0);
      exp_busy = (fire_left > 0) || (cool_left > 0);
   endtask

   task automatic step(input bit r, l, u, d, t, rs);
      @(negedge clk);
      i_right = r; i_left = l; i_up = u; i_down = d; i_trigger = t; i_rst = rs;
      model_edge(r, l, u, d, t, rs);
      @(posedge clk);
      #1;
      checks++;
      assert ({o_pan_pwm, o_tilt_pwm} === {exp_ppwm, exp_tpwm}) else begin
         failures++;
         $error("FAIL pwm n=%0d got=%b%b exp=%b%b", n_m, o_pan_pwm, o_tilt_pwm, exp_ppwm, exp_tpwm);
      end
      checks++;
      assert ({o_pan_pos, o_tilt_pos} === {8'(pan_m), 8'(tilt_m)}) else begin
         failures++;
         $error("FAIL pos n=%0d got=%0d/%0d exp=%0d/%0d", n_m, o_pan_pos, o_tilt_pos, pan_m, tilt_m);
      end
      checks++;
      assert ({o_fire, o_busy} === {exp_fire, exp_busy}) else begin
         failures++;
         $error("FAIL fire_busy n=%0d got=%b%b exp=%b%b", n_m, o_fire, o_busy, exp_fire, exp_busy);
      end
      pan_hi  += int'(o_pan_pwm);
      tilt_hi += int'(o_tilt_pwm);
      fire_hi += int'(o_fire);
      busy_hi += int'(o_busy);
      if (o_fire && !last_fire) fire_rises++;
      last_fire = o_fire;
   endtask

   task automatic run(input int nc, input bit r, l, u, d, t);
      for (int k = 0; k < nc; k++) step(r, l, u, d, t, 1'b0);
   endtask

   task automatic clear_counts();
      pan_hi = 0; tilt_hi = 0; fire_hi = 0; busy_hi = 0; fire_rises = 0;
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   initial begin
      bit rr, ll, uu, dd, tt;
      i_rst = 1'b1; i_right = 1'b0; i_left = 1'b0; i_up = 1'b0; i_down = 1'b0;
      i_trigger = 1'b0; last_fire = 1'b0;
      clear_counts();

      // Reset, then idle frames at center.
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1);
      check_int("rst_pan_pos", int'(o_pan_pos), CTR);
      check_int("rst_pwm", int'(o_pan_pwm), 0);
      clear_counts();
      run(P, 0, 0, 0, 0, 0);
      check_int("idle_pan_hi", pan_hi, 20);
      check_int("idle_tilt_hi", tilt_hi, 20);
      check_int("idle_fire_hi", fire_hi, 0);

      // Right held: pan walks up and saturates at POS_MAX.
      step(0, 0, 0, 0, 0, 1);
      run(15 * P, 1, 0, 0, 0, 0);
      check_int("sat_pan", int'(o_pan_pos), PMAX);
      check_int("sat_tilt", int'(o_tilt_pos), CTR);
      clear_counts();
      run(P, 1, 0, 0, 0, 0);
      check_int("sat_pan_hi", pan_hi, 30);
      check_int("sat_tilt_hi", tilt_hi, 20);

      // Opposing pan requests cancel; tilt steps down.
      step(0, 0, 0, 0, 0, 1);
      run(3 * P, 1, 1, 0, 1, 0);
      check_int("cancel_pan", int'(o_pan_pos), CTR);
      check_int("down_tilt", int'(o_tilt_pos), 7);
      clear_counts();
      run(P, 0, 0, 0, 0, 0);
      check_int("down_tilt_hi", tilt_hi, 17);
      check_int("cancel_pan_hi", pan_hi, 20);

      // Trigger held 30 cycles: a single fire/cooldown sequence.
      step(0, 0, 0, 0, 0, 1);
      run(10, 0, 0, 0, 0, 0);
      clear_counts();
      run(30, 0, 0, 0, 0, 1);
      run(20, 0, 0, 0, 0, 0);
      check_int("held_fire_hi", fire_hi, FIRE);
      check_int("held_busy_hi", busy_hi, FIRE + COOL);
      check_int("held_rises", fire_rises, 1);

      // Edge during cooldown is discarded; edge after idle refires.
      clear_counts();
      run(1, 0, 0, 0, 0, 1);
      run(6, 0, 0, 0, 0, 0);
      run(1, 0, 0, 0, 0, 1);
      run(20, 0, 0, 0, 0, 0);
      check_int("cool_edge_rises", fire_rises, 1);
      check_int("cool_edge_fire_hi", fire_hi, FIRE);
      run(1, 0, 0, 0, 0, 1);
      run(20, 0, 0, 0, 0, 0);
      check_int("refire_rises", fire_rises, 2);

      // Reset during FIRE and mid-pulse with pan=15.
      step(0, 0, 0, 0, 0, 1);
      run(5 * P, 1, 0, 0, 0, 0);
      check_int("pre_rst_pan", int'(o_pan_pos), 15);
      run(4, 0, 0, 0, 0, 1);
      check_int("pre_rst_fire", int'(o_fire), 1);
      check_int("pre_rst_pwm", int'(o_pan_pwm), 1);
      step(0, 0, 0, 0, 1, 1);
      check_int("mid_rst_fire", int'(o_fire), 0);
      check_int("mid_rst_busy", int'(o_busy), 0);
      check_int("mid_rst_pan", int'(o_pan_pos), CTR);
      check_int("mid_rst_pwm", int'(o_pan_pwm), 0);
      clear_counts();
      run(1, 0, 0, 0, 0, 1);
      check_int("restart_pwm", int'(o_pan_pwm), 1);
      run(P - 1, 0, 0, 0, 0, 1);
      check_int("restart_pan_hi", pan_hi, 20);
      check_int("held_after_rst_rises", fire_rises, 0);

      // Random traffic with occasional resets.
      rr = 0; ll = 0; uu = 0; dd = 0; tt = 0;
      for (int k = 0; k < 3000; k++) begin
         if ((k % 37) == 0) begin
            rr = 1'($urandom_range(0, 1)); ll = 1'($urandom_range(0, 1));
            uu = 1'($urandom_range(0, 1)); dd = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 5) == 0) tt = ~tt;
         step(rr, ll, uu, dd, tt, ($urandom_range(0, 799) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
